// File: rtl/avr_tx_scheduler.sv
// avr_tx_scheduler
//   Shares the byte-wide serial TX channel to the AVR between NUM_REQ requesters.
//   Round-robin arbitration. The grant is held for a whole packet, so bytes from
//   different requesters never interleave. The scheduler is gated by i_avr_ready
//   and by the AVR flow control inputs (i_tx_block, i_tx_busy).
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active-low
//   i_avr_ready    AVR configured and ready
//   i_req_valid    per requester: a byte is presented on i_req_data
//   i_req_last     per requester: the presented byte ends its packet
//   i_req_data     byte i at [8*i+7:8*i]
//   o_req_ready    per requester: byte taken when valid & ready (combinational)
//   i_tx_block     AVR buffer full, accept nothing
//   i_tx_busy      serial_tx is shifting a byte
//   o_tx_data      byte to serial_tx
//   o_new_tx_data  one-cycle strobe qualifying o_tx_data
//   o_grant        one-hot current owner, 0 when idle
//   o_abort        one-cycle pulse when a packet is cut short
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters when the AVR is ready
// SEND   | owner locked; wait for the owner's next byte
// EMIT   | strobe the accepted byte to serial_tx
// SETTLE | give serial_tx a cycle to raise tx_busy; end packet or go back to SEND

module avr_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_avr_ready,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ-1:0]     i_req_last,
  input  logic [NUM_REQ*8-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic                   i_tx_block,
  input  logic                   i_tx_busy,
  output logic [7:0]             o_tx_data,
  output logic                   o_new_tx_data,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_abort
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  // The counter value seen on the last tolerated idle cycle; the next idle
  // cycle is the TIMEOUT_CYCLES-th and revokes the grant.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_EMIT   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_tx_data;
  logic               r_new_tx_data;
  logic               r_abort;
  logic               r_last;
  logic [TMO_W-1:0]   r_tmo;

  logic [PTR_W-1:0]   w_pick;
  logic               w_found;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic [7:0]         w_owner_data;

  // Round-robin scan starting at r_ptr; first valid requester wins.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = idx[PTR_W-1:0];
      end
    end
  end

  assign w_owner_nxt  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_req_ready  = (r_state == ST_SEND && i_avr_ready && !i_tx_busy && !i_tx_block)
                        ? r_grant : '0;
  assign w_accept     = |(w_req_ready & i_req_valid);
  assign w_owner_data = i_req_data[{r_owner, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_grant       <= '0;
      r_tx_data     <= '0;
      r_new_tx_data <= 1'b0;
      r_abort       <= 1'b0;
      r_last        <= 1'b0;
      r_tmo         <= '0;
    end else begin
      r_new_tx_data <= 1'b0;
      r_abort       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (i_avr_ready && w_found) begin
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!i_avr_ready) begin
            r_abort <= 1'b1;
            r_grant <= '0;
            r_ptr   <= w_owner_nxt;
            r_tmo   <= '0;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_tx_data     <= w_owner_data;
            r_new_tx_data <= 1'b1;
            r_last        <= i_req_last[r_owner];
            r_tmo         <= '0;
            r_state       <= ST_EMIT;
          end else if (!i_req_valid[r_owner]) begin
            if (TMO_EN && r_tmo == TMO_LAST) begin
              r_abort <= 1'b1;
              r_grant <= '0;
              r_ptr   <= w_owner_nxt;
              r_tmo   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end else begin
            // Owner is presenting a byte but flow control holds it off.
            r_tmo <= '0;
          end
        end
        ST_EMIT: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_last) begin
            r_grant <= '0;
            r_ptr   <= w_owner_nxt;
            r_state <= ST_IDLE;
          end else if (!i_avr_ready) begin
            r_abort <= 1'b1;
            r_grant <= '0;
            r_ptr   <= w_owner_nxt;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_SEND;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready   = w_req_ready;
  assign o_tx_data     = r_tx_data;
  assign o_new_tx_data = r_new_tx_data;
  assign o_grant       = r_grant;
  assign o_abort       = r_abort;

endmodule

// File: tb/tb_avr_tx_scheduler.sv
// Testbench for avr_tx_scheduler: directed scenarios plus a randomized phase,
// checked every cycle against a transaction-level model of the scheduler.

module tb_avr_tx_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 8;
  localparam int QD   = 1024;
  localparam int LG   = 4096;

  logic              clk;
  logic              rst_n;
  logic              avr_ready;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_block;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic [NREQ-1:0]   grant;
  logic              abort;

  avr_tx_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_avr_ready  (avr_ready),
    .i_req_valid  (req_valid),
    .i_req_last   (req_last),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_tx_block   (tx_block),
    .i_tx_busy    (tx_busy),
    .o_tx_data    (tx_data),
    .o_new_tx_data(new_tx_data),
    .o_grant      (grant),
    .o_abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Requester byte queues: bit 8 marks the last byte of a packet.
  logic [8:0] pkt_mem [NREQ][QD];
  int rd [NREQ];
  int wr [NREQ];
  int gap[NREQ];
  bit rnd_gaps = 0;

  logic c_rst, c_avr, c_block, c_busy;
  int cyc = 0;

  // Logs of observed DUT behaviour.
  int         n_strobe = 0;
  int         s_cyc [LG];
  logic [7:0] s_byte[LG];
  int         n_abort = 0;
  int         a_cyc [LG];
  int         n_g = 0;
  logic [3:0] g_log [LG];
  logic [3:0] prev_grant = '0;
  int         acc_cyc = -1;

  // Transaction-level model: owner index (-1 = none), cycles since the byte
  // was taken (0 = waiting for a byte, 1 = strobe cycle, 2 = settle cycle).
  int         m_own, m_ptr, m_since, m_idle;
  bit         m_last, m_strobe, m_abort;
  logic [7:0] m_data;

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_since = 0; m_idle = 0;
    m_last = 0; m_strobe = 0; m_abort = 0; m_data = 8'h00;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input bit last);
    if (wr[i] < QD) begin
      pkt_mem[i][wr[i]] = {last, b};
      wr[i]++;
    end
  endtask

  task automatic release_packet(input int owner);
    m_ptr = (owner + 1) % NREQ;
    m_own = -1;
  endtask

  task automatic step();
    logic [3:0] exp_grant, exp_rdy, acc;
    bit nstrobe, nabort, found;
    int j;
    rst_n = c_rst; avr_ready = c_avr; tx_block = c_block; tx_busy = c_busy;
    for (int i = 0; i < NREQ; i++) begin
      bit v;
      v = (rd[i] < wr[i]) && (rd[i] < QD) && (gap[i] == 0);
      req_valid[i]      = v;
      req_last[i]       = v ? pkt_mem[i][rd[i]][8] : 1'b0;
      req_data[8*i +: 8] = v ? pkt_mem[i][rd[i]][7:0] : 8'h00;
    end
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    exp_grant = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    exp_rdy   = (m_own >= 0 && m_since == 0 && avr_ready && !tx_busy && !tx_block)
                ? exp_grant : 4'b0000;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("new_tx_data", 32'(new_tx_data), 32'(m_strobe));
    chk("abort", 32'(abort), 32'(m_abort));
    if (m_strobe) chk("tx_data", 32'(tx_data), 32'(m_data));
    // Observation logs.
    if (new_tx_data) begin
      if (n_strobe < LG) begin s_cyc[n_strobe] = cyc; s_byte[n_strobe] = tx_data; end
      n_strobe++;
    end
    if (abort) begin
      if (n_abort < LG) a_cyc[n_abort] = cyc;
      n_abort++;
    end
    if (grant != prev_grant) begin
      if (n_g < LG) g_log[n_g] = grant;
      n_g++;
      prev_grant = grant;
    end
    if (|(req_ready & req_valid)) acc_cyc = cyc;
    // Model advance.
    acc = exp_rdy & req_valid;
    nstrobe = 0; nabort = 0;
    if (rst_n) begin
      if (m_own < 0) begin
        if (avr_ready && |req_valid) begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!found && req_valid[j]) begin found = 1; m_own = j; end
          end
          m_since = 0; m_idle = 0;
        end
      end else if (m_since == 0) begin
        if (!avr_ready) begin
          nabort = 1; release_packet(m_own);
        end else if (|acc) begin
          m_data = req_data[8*m_own +: 8]; m_last = req_last[m_own];
          nstrobe = 1; m_since = 1;
        end else if (!req_valid[m_own]) begin
          m_idle++;
          if (TMO != 0 && m_idle == TMO) begin nabort = 1; release_packet(m_own); end
        end else begin
          m_idle = 0;
        end
      end else if (m_since == 1) begin
        m_since = 2;
      end else begin
        if (m_last) release_packet(m_own);
        else if (!avr_ready) begin nabort = 1; release_packet(m_own); end
        else begin m_since = 0; m_idle = 0; end
      end
    end
    m_strobe = nstrobe; m_abort = nabort;
    // Requester side: pop accepted bytes, optional gaps before the next one.
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        rd[i]++;
        if (rnd_gaps)
          gap[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 2);
      end else if (!req_valid[i] && gap[i] > 0) begin
        gap[i]--;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input int limit);
    int base;
    base = n_strobe;
    for (int k = 0; k < limit && n_strobe == base; k++) step();
    chk("wait_strobe", 32'(n_strobe > base), 32'd1);
  endtask

  task automatic do_reset();
    c_rst = 1'b0;
    repeat (2) step();
    c_rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bs, bg, ba, t0, nz;
    bit hit;
    logic [7:0] exp3 [8];
    logic [3:0] nzg  [8];
    logic [3:0] expg [6];
    exp3 = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    expg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < NREQ; i++) begin rd[i] = 0; wr[i] = 0; gap[i] = 0; end
    model_reset();
    c_rst = 0; c_avr = 1; c_block = 0; c_busy = 0;
    rst_n = 0; avr_ready = 0; tx_block = 0; tx_busy = 0;
    req_valid = '0; req_last = '0; req_data = '0;
    #2;
    repeat (3) step();
    c_rst = 1;
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_strobe", 32'(new_tx_data), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);

    // avr_ready low: request held, nothing granted.
    bs = n_strobe; bg = n_g;
    c_avr = 0;
    push(0, 8'h11, 1);
    repeat (100) step();
    chk("noavr_strobes", 32'(n_strobe - bs), 32'd0);
    chk("noavr_grants", 32'(n_g - bg), 32'd0);
    chk("noavr_ready", 32'(req_ready), 32'd0);
    c_avr = 1;
    wait_strobe(10);
    chk("noavr_byte", 32'(s_byte[bs]), 32'h11);
    repeat (3) step();

    // Three-byte packet from requester 2.
    bs = n_strobe; bg = n_g; ba = n_abort;
    push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
    repeat (20) step();
    chk("pkt_count", 32'(n_strobe - bs), 32'd3);
    chk("pkt_b0", 32'(s_byte[bs]), 32'h41);
    chk("pkt_b1", 32'(s_byte[bs+1]), 32'h42);
    chk("pkt_b2", 32'(s_byte[bs+2]), 32'h43);
    chk("pkt_gap01", 32'(s_cyc[bs+1] - s_cyc[bs]), 32'd3);
    chk("pkt_gap12", 32'(s_cyc[bs+2] - s_cyc[bs+1]), 32'd3);
    chk("pkt_grant_changes", 32'(n_g - bg), 32'd2);
    chk("pkt_grant_on", 32'(g_log[bg]), 32'h4);
    chk("pkt_grant_off", 32'(g_log[bg+1]), 32'h0);
    chk("pkt_no_abort", 32'(n_abort - ba), 32'd0);

    // All four requesters, two single-byte packets each, from reset.
    do_reset();
    bs = n_strobe; bg = n_g;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push(i, 8'(i*16 + k), 1);
    repeat (45) step();
    nz = 0;
    for (int k = bg; k < n_g && k < LG; k++)
      if (g_log[k] != 4'b0000 && nz < 8) begin nzg[nz] = g_log[k]; nz++; end
    chk("rr_grant_count", 32'(nz), 32'd8);
    for (int k = 0; k < 6; k++) chk("rr_grant_order", 32'(nzg[k]), 32'(expg[k]));
    chk("rr_strobes", 32'(n_strobe - bs), 32'd8);
    for (int k = 0; k < 8; k++) chk("rr_bytes", 32'(s_byte[bs+k]), 32'(exp3[k]));

    // tx_block held while SEND with valid asserted.
    bs = n_strobe; ba = n_abort;
    c_block = 1;
    push(0, 8'h5A, 1);
    repeat (22) step();
    chk("blk_no_strobe", 32'(n_strobe - bs), 32'd0);
    chk("blk_grant", 32'(grant), 32'h1);
    chk("blk_ready", 32'(req_ready), 32'd0);
    chk("blk_no_abort", 32'(n_abort - ba), 32'd0);
    c_block = 0;
    t0 = cyc + 1;
    repeat (2) step();
    chk("blk_accept_cycle", 32'(acc_cyc), 32'(t0));
    chk("blk_strobe_cycle", 32'(s_cyc[bs]), 32'(t0 + 1));
    chk("blk_strobe_byte", 32'(s_byte[bs]), 32'h5A);
    repeat (3) step();

    // Timeout: requester 1 stalls after its first byte, requester 3 waits.
    bs = n_strobe; bg = n_g; ba = n_abort;
    push(1, 8'hC1, 0);
    push(3, 8'h77, 1);
    repeat (30) step();
    chk("tmo_abort_count", 32'(n_abort - ba), 32'd1);
    chk("tmo_abort_cycle", 32'(a_cyc[ba]), 32'(s_cyc[bs] + 10));
    chk("tmo_grant0", 32'(g_log[bg]), 32'h2);
    chk("tmo_grant1", 32'(g_log[bg+1]), 32'h0);
    chk("tmo_grant2", 32'(g_log[bg+2]), 32'h8);
    chk("tmo_next_byte", 32'(s_byte[bs+1]), 32'h77);
    push(1, 8'hC2, 1);
    repeat (8) step();

    // avr_ready lost mid-packet.
    ba = n_abort;
    push(0, 8'hA0, 0);
    wait_strobe(10);
    step();
    c_avr = 0;
    repeat (3) step();
    chk("avrloss_abort", 32'(n_abort - ba), 32'd1);
    chk("avrloss_grant", 32'(grant), 32'd0);
    chk("avrloss_abort_low", 32'(abort), 32'd0);
    c_avr = 1;
    push(0, 8'hA1, 1);
    wait_strobe(10);
    repeat (3) step();

    // Reset pulse during EMIT.
    push(0, 8'hB0, 1);
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      step();
      hit = m_strobe;
    end
    chk("emit_reached", 32'(hit), 32'd1);
    chk("emit_strobe", 32'(new_tx_data), 32'd1);
    chk("emit_byte", 32'(tx_data), 32'hB0);
    #2;
    c_rst = 0; rst_n = 0;
    #1;
    chk("midrst_strobe", 32'(new_tx_data), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_abort", 32'(abort), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    repeat (2) step();
    c_rst = 1;
    step();

    // Randomized traffic with gaps, flow control and avr_ready drops.
    rnd_gaps = 1;
    repeat (3000) begin
      c_avr   = ($urandom_range(0, 99) >= 3);
      c_block = ($urandom_range(0, 99) < 20);
      c_busy  = ($urandom_range(0, 99) < 30);
      for (int i = 0; i < NREQ; i++) begin
        if (wr[i] - rd[i] < 3 && wr[i] + 3 <= QD && $urandom_range(0, 9) == 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      step();
    end
    rnd_gaps = 0;
    c_avr = 1; c_block = 0; c_busy = 0;
    repeat (200) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
